fft_peak_detect: RTL and testbench

//  Downstream consumer of the 32-point streaming FFT output (17-bit signed re/im, natural bin order).

---
 rtl/fft_peak_detect_if.sv | 29 ++
 rtl/fft_peak_detect.sv | 205 ++++++++++++++++++++
 tb/tb_fft_peak_detect.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_peak_detect_if.sv
// Streaming FFT sample input and frame-peak result port of the peak detector.
// The master side is the FFT/result consumer; the slave side is the detector.
interface fft_peak_detect_if #(
  parameter int DW   = 17,
  parameter int IDXW = 5,
  parameter int MAGW = 34
);
  logic                   in_valid;
  logic                   in_sof;
  logic signed [DW-1:0]   in_real;
  logic signed [DW-1:0]   in_imag;
  logic                   peak_valid;
  logic                   peak_ready;
  logic [IDXW-1:0]        peak_bin;
  logic [MAGW-1:0]        peak_mag;
  logic                   frame_err;
  logic                   ovf;
  logic                   busy;

  modport master (
    output in_valid, in_sof, in_real, in_imag, peak_ready,
    input  peak_valid, peak_bin, peak_mag, frame_err, ovf, busy
  );

  modport slave (
    input  in_valid, in_sof, in_real, in_imag, peak_ready,
    output peak_valid, peak_bin, peak_mag, frame_err, ovf, busy
  );
endinterface

// File: rtl/fft_peak_detect.sv
// Per-frame peak finder for a 32-point streaming FFT: squared magnitude per bin,
// running maximum per frame, one {bin, magnitude} result per frame over valid/ready.
module fft_peak_detect #(
  parameter int DW   = 17,
  parameter int N    = 32,
  parameter int IDXW = 5,
  parameter int MAGW = 34
) (
  input  logic             clk,
  input  logic             rst,
  fft_peak_detect_if.slave bus
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [IDXW-1:0]        cnt_q, cnt_d;
  logic                   frame_err_q, frame_err_d;

  // Capture stage: raw sample plus its bin tag
  logic                   s0_valid_q, s0_valid_d;
  logic                   s0_first_q, s0_first_d;
  logic                   s0_last_q, s0_last_d;
  logic [IDXW-1:0]        s0_bin_q, s0_bin_d;
  logic signed [DW-1:0]   s0_re_q, s0_im_q;

  // Stage A: squared components
  logic                   a_valid_q, a_first_q, a_last_q;
  logic [IDXW-1:0]        a_bin_q;
  logic [MAGW-1:0]        a_sq_re_q, a_sq_im_q, a_sq_re_d, a_sq_im_d;
  logic signed [2*DW-1:0] re_ext_s, im_ext_s, prod_re_s, prod_im_s;

  // Stage B: squared magnitude
  logic                   b_valid_q, b_first_q, b_last_q;
  logic [IDXW-1:0]        b_bin_q;
  logic [MAGW-1:0]        b_mag_q, b_mag_d;

  logic [MAGW-1:0]        best_mag_q, cand_mag_s;
  logic [IDXW-1:0]        best_bin_q, cand_bin_s;
  logic                   take_s, load_s;

  logic                   peak_valid_q, peak_valid_d;
  logic [IDXW-1:0]        peak_bin_q, peak_bin_d;
  logic [MAGW-1:0]        peak_mag_q, peak_mag_d;
  logic                   ovf_q, ovf_d;

  // Frame sequencing: an sof while accumulating aborts the partial frame and restarts at bin 0.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    frame_err_d = 1'b0;
    s0_valid_d  = 1'b0;
    s0_first_d  = 1'b0;
    s0_last_d   = 1'b0;
    s0_bin_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid && bus.in_sof) begin
          state_d    = ACC;
          cnt_d      = IDXW'(1);
          s0_valid_d = 1'b1;
          s0_first_d = 1'b1;
          s0_bin_d   = IDXW'(0);
        end else begin
          state_d = IDLE;
        end
      end
      ACC: begin
        if (bus.in_valid && bus.in_sof) begin
          frame_err_d = 1'b1;
          cnt_d       = IDXW'(1);
          s0_valid_d  = 1'b1;
          s0_first_d  = 1'b1;
          s0_bin_d    = IDXW'(0);
        end else if (bus.in_valid) begin
          s0_valid_d = 1'b1;
          s0_bin_d   = cnt_q;
          if (cnt_q == IDXW'(N - 1)) begin
            s0_last_d = 1'b1;
            state_d   = IDLE;
            cnt_d     = IDXW'(0);
          end else begin
            cnt_d = cnt_q + IDXW'(1);
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = IDXW'(0);
      end
    endcase
  end

  always_comb begin
    re_ext_s   = {{DW{s0_re_q[DW-1]}}, s0_re_q};
    im_ext_s   = {{DW{s0_im_q[DW-1]}}, s0_im_q};
    prod_re_s  = re_ext_s * re_ext_s;
    prod_im_s  = im_ext_s * im_ext_s;
    a_sq_re_d  = $unsigned(prod_re_s);
    a_sq_im_d  = $unsigned(prod_im_s);
    b_mag_d    = a_sq_re_q + a_sq_im_q;
    // Strict compare keeps the lower bin on ties; bin 0 always reloads.
    take_s     = b_first_q | (b_mag_q > best_mag_q);
    cand_mag_s = take_s ? b_mag_q : best_mag_q;
    cand_bin_s = take_s ? b_bin_q : best_bin_q;
    load_s     = b_valid_q & b_last_q;
  end

  // A result arriving while the previous one is still unaccepted is dropped.
  always_comb begin
    peak_valid_d = peak_valid_q;
    peak_bin_d   = peak_bin_q;
    peak_mag_d   = peak_mag_q;
    ovf_d        = 1'b0;
    if (load_s) begin
      if (peak_valid_q && !bus.peak_ready) begin
        ovf_d = 1'b1;
      end else begin
        peak_valid_d = 1'b1;
        peak_bin_d   = cand_bin_s;
        peak_mag_d   = cand_mag_s;
      end
    end else if (peak_valid_q && bus.peak_ready) begin
      peak_valid_d = 1'b0;
    end else begin
      peak_valid_d = peak_valid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= IDXW'(0);
      frame_err_q  <= 1'b0;
      s0_valid_q   <= 1'b0;
      s0_first_q   <= 1'b0;
      s0_last_q    <= 1'b0;
      s0_bin_q     <= IDXW'(0);
      s0_re_q      <= DW'(0);
      s0_im_q      <= DW'(0);
      a_valid_q    <= 1'b0;
      a_first_q    <= 1'b0;
      a_last_q     <= 1'b0;
      a_bin_q      <= IDXW'(0);
      a_sq_re_q    <= MAGW'(0);
      a_sq_im_q    <= MAGW'(0);
      b_valid_q    <= 1'b0;
      b_first_q    <= 1'b0;
      b_last_q     <= 1'b0;
      b_bin_q      <= IDXW'(0);
      b_mag_q      <= MAGW'(0);
      best_mag_q   <= MAGW'(0);
      best_bin_q   <= IDXW'(0);
      peak_valid_q <= 1'b0;
      peak_bin_q   <= IDXW'(0);
      peak_mag_q   <= MAGW'(0);
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      frame_err_q  <= frame_err_d;
      s0_valid_q   <= s0_valid_d;
      s0_first_q   <= s0_first_d;
      s0_last_q    <= s0_last_d;
      s0_bin_q     <= s0_bin_d;
      s0_re_q      <= bus.in_real;
      s0_im_q      <= bus.in_imag;
      a_valid_q    <= s0_valid_q;
      a_first_q    <= s0_first_q;
      a_last_q     <= s0_last_q;
      a_bin_q      <= s0_bin_q;
      a_sq_re_q    <= a_sq_re_d;
      a_sq_im_q    <= a_sq_im_d;
      b_valid_q    <= a_valid_q;
      b_first_q    <= a_first_q;
      b_last_q     <= a_last_q;
      b_bin_q      <= a_bin_q;
      b_mag_q      <= b_mag_d;
      if (b_valid_q) begin
        best_mag_q <= cand_mag_s;
        best_bin_q <= cand_bin_s;
      end else begin
        best_mag_q <= best_mag_q;
        best_bin_q <= best_bin_q;
      end
      peak_valid_q <= peak_valid_d;
      peak_bin_q   <= peak_bin_d;
      peak_mag_q   <= peak_mag_d;
      ovf_q        <= ovf_d;
    end
  end

  assign bus.peak_valid = peak_valid_q;
  assign bus.peak_bin   = peak_bin_q;
  assign bus.peak_mag   = peak_mag_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.ovf        = ovf_q;
  assign bus.busy       = (state_q == ACC) | s0_valid_q | a_valid_q | b_valid_q;

endmodule

// File: tb/tb_fft_peak_detect.sv
// Scoreboard bench for fft_peak_detect: the driver pushes each complete frame's argmax
// (from plain arithmetic over the stored frame) and a negedge monitor checks every handshake.
module tb_fft_peak_detect;
  localparam int DW   = 17;
  localparam int N    = 32;
  localparam int IDXW = 5;
  localparam int MAGW = 34;

  typedef struct {
    int     bin;
    longint mag;
    int     due;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fft_peak_detect_if #(.DW(DW), .IDXW(IDXW), .MAGW(MAGW)) bus ();

  fft_peak_detect #(.DW(DW), .N(N), .IDXW(IDXW), .MAGW(MAGW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t                 exp_q[$];
  int                   n_checks = 0;
  int                   n_pass   = 0;
  int                   cyc      = 0;
  int                   ferr_seen = 0, ovf_seen = 0, exp_ferr = 0, exp_ovf = 0;
  logic signed [DW-1:0] fr_re[N];
  logic signed [DW-1:0] fr_im[N];
  bit                   prev_v = 1'b0;
  int                   rise_cyc = 0;
  exp_t                 e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint expv);
    n_checks++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, expv);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic sof,
                       input logic signed [DW-1:0] re, input logic signed [DW-1:0] im);
    tick();
    bus.in_valid = v;
    bus.in_sof   = sof;
    bus.in_real  = re;
    bus.in_imag  = im;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      tick();
      bus.in_valid = 1'b0;
      bus.in_sof   = 1'b0;
    end
  endtask

  // Reference: largest re^2+im^2 over the stored frame, first occurrence wins.
  function automatic void model_push(input int due);
    exp_t   x;
    longint m;
    x.mag = -1;
    x.bin = 0;
    x.due = due;
    for (int i = 0; i < N; i++) begin
      m = longint'(fr_re[i]) * longint'(fr_re[i]) + longint'(fr_im[i]) * longint'(fr_im[i]);
      if (m > x.mag) begin
        x.mag = m;
        x.bin = i;
      end
    end
    exp_q.push_back(x);
  endfunction

  task automatic send_frame(input int nbins, input int bub_pct, input bit keep);
    for (int i = 0; i < nbins; i++) begin
      if (i > 0 && int'($urandom_range(99)) < bub_pct) idle(int'($urandom_range(3, 1)));
      drive(1'b1, (i == 0), fr_re[i], fr_im[i]);
    end
    // last sample is sampled at edge cyc+1; result visible after edge cyc+4
    if (nbins == N && keep) model_push(cyc + 4);
  endtask

  function automatic void fill_const(input int re, input int im);
    for (int i = 0; i < N; i++) begin
      fr_re[i] = DW'(re);
      fr_im[i] = DW'(im);
    end
  endfunction

  function automatic void fill_rand(input int mode);
    int t;
    for (int i = 0; i < N; i++) begin
      if (mode == 1) begin
        t = int'($urandom_range(6)) - 3;
        fr_re[i] = DW'(t);
        t = int'($urandom_range(6)) - 3;
        fr_im[i] = DW'(t);
      end else begin
        fr_re[i] = DW'($urandom());
        fr_im[i] = DW'($urandom());
      end
    end
    if (mode == 2) begin
      t = int'($urandom_range(N - 1));
      fr_re[int'($urandom_range(N - 1))] = fr_re[t];
      fr_im[int'($urandom_range(N - 1))] = fr_im[t];
      fr_re[N - 1] = fr_re[t];
      fr_im[N - 1] = fr_im[t];
    end
  endfunction

  // Monitor: each accepted result is compared against the scoreboard head.
  always @(negedge clk) begin
    if (rst) begin
      prev_v = 1'b0;
    end else begin
      if (bus.frame_err) ferr_seen++;
      if (bus.ovf) ovf_seen++;
      if (bus.peak_valid && !prev_v) rise_cyc = cyc;
      if (bus.peak_valid && bus.peak_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_result: got bin %0d mag %0d, none required",
                   bus.peak_bin, bus.peak_mag);
        end else begin
          e = exp_q.pop_front();
          check("peak_bin", longint'(bus.peak_bin), longint'(e.bin));
          check("peak_mag", longint'(bus.peak_mag), e.mag);
          check("result_latency", longint'(rise_cyc), longint'(e.due));
        end
        prev_v = 1'b0;
      end else begin
        prev_v = bus.peak_valid;
      end
    end
  end

  initial begin
    int waited;
    rst            = 1'b1;
    bus.in_valid   = 1'b0;
    bus.in_sof     = 1'b0;
    bus.in_real    = '0;
    bus.in_imag    = '0;
    bus.peak_ready = 1'b1;
    repeat (3) tick();
    check("rst_peak_valid", longint'(bus.peak_valid), 0);
    check("rst_peak_bin", longint'(bus.peak_bin), 0);
    check("rst_peak_mag", longint'(bus.peak_mag), 0);
    check("rst_busy", longint'(bus.busy), 0);
    check("rst_pulses", longint'(bus.frame_err | bus.ovf), 0);
    rst = 1'b0;
    idle(2);

    // bin 5 = (1000,-1000) among (1,1)
    fill_const(1, 1);
    fr_re[5] = 17'sd1000;
    fr_im[5] = -17'sd1000;
    send_frame(N, 0, 1'b1);
    idle(8);

    // full-scale negative on every bin
    fill_const(-65536, -65536);
    send_frame(N, 0, 1'b1);
    idle(8);

    // tie between bins 3 and 17
    fill_const(0, 0);
    fr_re[3]  = 17'sd300;
    fr_im[3]  = 17'sd400;
    fr_re[17] = 17'sd300;
    fr_im[17] = 17'sd400;
    send_frame(N, 0, 1'b1);
    idle(8);

    // back-to-back frames with the result port stalled: second result dropped
    bus.peak_ready = 1'b0;
    fill_rand(0);
    send_frame(N, 0, 1'b1);
    fill_rand(0);
    send_frame(N, 0, 1'b0);
    exp_ovf++;
    idle(6);
    bus.peak_ready = 1'b1;
    idle(4);
    check("ovf_count", longint'(ovf_seen), longint'(exp_ovf));

    // early sof at bin 12, then a full frame peaking at bin 9
    fill_rand(0);
    send_frame(12, 0, 1'b0);
    exp_ferr++;
    for (int i = 0; i < N; i++) begin
      fr_re[i] = DW'($urandom_range(100));
      fr_im[i] = DW'($urandom_range(100));
    end
    fr_re[9] = 17'sd1000;
    fr_im[9] = 17'sd1000;
    send_frame(N, 0, 1'b1);
    idle(8);
    check("frame_err_count", longint'(ferr_seen), longint'(exp_ferr));

    // frame with bubbles; then a pending result and a partial frame killed by rst
    fill_rand(2);
    send_frame(N, 40, 1'b1);
    idle(6);
    bus.peak_ready = 1'b0;
    fill_rand(0);
    send_frame(N, 0, 1'b1);
    waited = 0;
    while (!bus.peak_valid && waited < 20) begin
      idle(1);
      waited++;
    end
    check("pending_before_rst", longint'(bus.peak_valid), 1);
    fill_rand(0);
    send_frame(20, 0, 1'b0);
    tick();
    rst          = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_sof   = 1'b0;
    bus.in_real  = fr_re[20];
    bus.in_imag  = fr_im[20];
    exp_q.delete();
    tick();
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    check("post_rst_peak_valid", longint'(bus.peak_valid), 0);
    check("post_rst_busy", longint'(bus.busy), 0);
    bus.peak_ready = 1'b1;
    idle(10);

    // randomized frames, optionally back-to-back
    for (int f = 0; f < 16; f++) begin
      fill_rand(int'($urandom_range(2)));
      send_frame(N, int'($urandom_range(30)), 1'b1);
      if ($urandom_range(1) == 0) idle(int'($urandom_range(5)));
    end
    idle(1);

    waited = 0;
    while (exp_q.size() != 0 && waited < 200) begin
      idle(1);
      waited++;
    end
    check("scoreboard_drained", longint'(exp_q.size()), 0);
    check("final_ovf_count", longint'(ovf_seen), longint'(exp_ovf));
    check("final_frame_err_count", longint'(ferr_seen), longint'(exp_ferr));
    check("final_busy", longint'(bus.busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
